da_column_filter: RTL and testbench



---
 rtl/da_column_filter.sv | 181 ++++++++++++++++++
 tb/tb_da_column_filter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/da_column_filter.sv
// Bit-serial distributed-arithmetic column filter: signed dot product of KERNEL_H
// unsigned pixels with loadable signed weights, using one 16-entry LUT per 4-tap group.
module da_column_filter #(
    parameter int PIX_W    = 8,
    parameter int KERNEL_H = 7,
    parameter int WEIGHT_W = 5,
    parameter int OUT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         w_load,
    input  logic [KERNEL_H*WEIGHT_W-1:0] w_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [KERNEL_H*PIX_W-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_W-1:0]      out_data,
    output logic                         out_ovf
);

    localparam int NGRP  = (KERNEL_H + 3) / 4;
    localparam int LUT_W = WEIGHT_W + 2;
    localparam int ACC_W = PIX_W + WEIGHT_W + $clog2(KERNEL_H) + 1;
    localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam int CNT_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;
    localparam int WP_W  = NGRP * 4 * WEIGHT_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic signed [EXT_W-1:0] SAT_MAX =
        $signed({{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [EXT_W-1:0] SAT_MIN =
        $signed({{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

    // Sum of the group's weights selected by the set bits of idx.
    function automatic logic signed [LUT_W-1:0] lut_entry(
        input logic [WP_W-1:0] w,
        input int              g,
        input logic [3:0]      idx
    );
        logic signed [LUT_W-1:0] s;
        s = '0;
        for (int b = 0; b < 4; b++) begin
            s = s + (idx[b] ? LUT_W'($signed(w[(g*4+b)*WEIGHT_W +: WEIGHT_W]))
                            : LUT_W'(0));
        end
        return s;
    endfunction

    // Clip to the signed output range; MSB of the result is the overflow flag.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] a);
        logic signed [EXT_W-1:0] e;
        logic [OUT_W:0]          r;
        e = EXT_W'(a);
        if (e > SAT_MAX) begin
            r = {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (e < SAT_MIN) begin
            r = {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            r = {1'b0, e[OUT_W-1:0]};
        end
        return r;
    endfunction

    logic [1:0]                  state_r;
    logic [CNT_W-1:0]            cnt_r;
    logic [KERNEL_H*PIX_W-1:0]   pix_r;
    logic signed [ACC_W-1:0]     acc_r;
    logic                        in_ready_r;
    logic                        out_valid_r;
    logic signed [OUT_W-1:0]     out_data_r;
    logic                        out_ovf_r;
    logic signed [LUT_W-1:0]     lut_r [NGRP][16];

    logic [WP_W-1:0]             w_pad_s;
    logic [NGRP*4-1:0]           tap_bits_s;
    logic signed [ACC_W-1:0]     part_s;
    logic signed [ACC_W-1:0]     acc_next_s;
    logic [OUT_W:0]              sat_s;
    logic                        accept_s;
    logic                        last_s;

    // Taps missing from the top group see zero weights.
    assign w_pad_s  = WP_W'(w_data);
    assign accept_s = (state_r == ST_IDLE) && in_valid;
    assign last_s   = (cnt_r == CNT_W'(PIX_W - 1));

    // Current bit of every pixel; the shift register presents bit k at each tap's LSB.
    always_comb begin
        tap_bits_s = '0;
        for (int t = 0; t < KERNEL_H; t++) begin
            tap_bits_s[t] = pix_r[t*PIX_W];
        end
    end

    // Partial sum across groups, weighted into the accumulator at bit position k.
    always_comb begin
        part_s = '0;
        for (int g = 0; g < NGRP; g++) begin
            part_s = part_s + ACC_W'(lut_r[g][tap_bits_s[g*4 +: 4]]);
        end
        acc_next_s = acc_r + (part_s <<< cnt_r);
        sat_s      = saturate(acc_next_s);
    end

    // Per-group LUTs, rewritten only while idle so a load lands before the first BUSY read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NGRP; g++) begin
                for (int i = 0; i < 16; i++) begin
                    lut_r[g][i] <= '0;
                end
            end
        end else if ((state_r == ST_IDLE) && w_load) begin
            for (int g = 0; g < NGRP; g++) begin
                for (int i = 0; i < 16; i++) begin
                    lut_r[g][i] <= lut_entry(w_pad_s, g, 4'(i));
                end
            end
        end
    end

    // Control FSM, serial datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            pix_r       <= '0;
            acc_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        pix_r      <= in_data;
                        acc_r      <= '0;
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_r <= acc_next_s;
                    pix_r <= pix_r >> 1;
                    if (last_s) begin
                        out_data_r  <= $signed(sat_s[OUT_W-1:0]);
                        out_ovf_r   <= sat_s[OUT_W];
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_da_column_filter.sv
// Directed bench for da_column_filter: a 16-bit and an 8-bit output instance run in lockstep.
module tb_da_column_filter;

    localparam int PIX_W = 8;
    localparam int KH    = 7;
    localparam int WW    = 5;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   w_load = 1'b0;
    logic [KH*WW-1:0]       w_data = '0;
    logic                   in_valid = 1'b0;
    logic [KH*PIX_W-1:0]    in_data = '0;
    logic                   out_ready = 1'b0;

    logic                   in_ready_a, out_valid_a, ovf_a;
    logic signed [15:0]     data_a;
    logic                   in_ready_b, out_valid_b, ovf_b;
    logic signed [7:0]      data_b;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [KH*WW-1:0] w_def;
    logic [KH*WW-1:0] w_ones;

    always #5 clk = ~clk;

    da_column_filter #(.PIX_W(PIX_W), .KERNEL_H(KH), .WEIGHT_W(WW), .OUT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(data_a), .out_ovf(ovf_a)
    );

    da_column_filter #(.PIX_W(PIX_W), .KERNEL_H(KH), .WEIGHT_W(WW), .OUT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(data_b), .out_ovf(ovf_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [KH*PIX_W-1:0] pix(input logic [KH-1:0] m, input logic [7:0] v);
        logic [KH*PIX_W-1:0] p;
        p = '0;
        for (int k = 0; k < KH; k++) begin
            if (m[k]) p[k*PIX_W +: PIX_W] = v;
        end
        return p;
    endfunction

    task automatic accept(input logic ld, input logic [KH*WW-1:0] wd, input logic [KH*PIX_W-1:0] p);
        @(negedge clk);
        w_load = ld; w_data = wd; in_data = p; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("accept_in_ready", int'(in_ready_a), 0);
        @(negedge clk);
        in_valid = 1'b0; w_load = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int n;
        n = start;
        while (!out_valid_a && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, PIX_W);
        chk("valid_b", int'(out_valid_b), 1);
    endtask

    task automatic check_res(input string tag, input int e16, input int o16, input int e8, input int o8);
        chk({tag, "_data16"}, int'(data_a), e16);
        chk({tag, "_ovf16"},  int'(ovf_a),  o16);
        chk({tag, "_data8"},  int'(data_b), e8);
        chk({tag, "_ovf8"},   int'(ovf_b),  o8);
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_out_valid", int'(out_valid_a), 0);
        chk("hs_in_ready",  int'(in_ready_a),  1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int def_w [KH] = '{1, -2, 3, -4, 5, -6, 7};
        for (int k = 0; k < KH; k++) w_def[k*WW +: WW] = WW'(def_w[k]);
        w_ones = '1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  int'(in_ready_a),  1);
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_data",      int'(data_a),      0);
        chk("rst_ovf",       int'(ovf_a),       0);
        @(negedge clk);
        rst_n = 1'b1;

        // Weights loaded on the same edge as the accept; all pixels 255
        accept(1'b1, w_def, pix(7'h7F, 8'd255));
        wait_done(0);
        check_res("all255", 1020, 0, 127, 1);
        // Stall in DONE for 5 cycles
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_data",     int'(data_a),      1020);
            chk("stall_in_ready", int'(in_ready_a),  0);
            chk("stall_valid",    int'(out_valid_a), 1);
        end
        handshake();

        accept(1'b0, w_def, pix(7'b1000000, 8'd255));
        wait_done(0);
        check_res("tap6", 1785, 0, 127, 1);
        handshake();

        accept(1'b0, w_def, pix(7'b0101010, 8'd255));
        wait_done(0);
        check_res("tap135", -3060, 0, -128, 1);
        handshake();

        accept(1'b0, w_def, pix(7'h7F, 8'd0));
        wait_done(0);
        check_res("zero", 0, 0, 0, 0);
        handshake();

        // Weight load during BUSY is ignored
        accept(1'b0, w_def, pix(7'h7F, 8'd1));
        @(negedge clk);
        w_load = 1'b1; w_data = w_ones;
        @(negedge clk);
        w_load = 1'b0;
        wait_done(2);
        check_res("busy_load", 4, 0, 4, 0);
        handshake();

        // Load in IDLE together with accept: new weights apply
        accept(1'b1, w_ones, pix(7'h7F, 8'd1));
        wait_done(0);
        check_res("idle_load", -7, 0, -7, 0);
        handshake();

        // Asynchronous reset mid-BUSY clears outputs and tables
        accept(1'b1, w_def, pix(7'h7F, 8'd255));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid_a), 0);
        chk("arst_in_ready",  int'(in_ready_a),  1);
        chk("arst_data",      int'(data_a),      0);
        @(negedge clk);
        rst_n = 1'b1;
        accept(1'b0, w_def, pix(7'h7F, 8'd255));
        wait_done(0);
        check_res("post_rst", 0, 0, 0, 0);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
